// File: rtl/fare_gate_array_ctrl.sv
// Multi-lane fare gate controller: per-lane tap/validate/open-or-deny FSMs
// with global maintenance override and a shared saturating entry counter.
module fare_gate_lane #(
    parameter int OPEN_CYCLES = 50,
    parameter int DENY_CYCLES = 20,
    parameter int TMR_W       = 6
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_maintenance,
    input  logic       i_nfc,
    input  logic       i_card_active,
    input  logic       i_fund_enough,
    input  logic       i_pass_done,
    output logic       o_open,
    output logic       o_reduce_bal,
    output logic [2:0] o_disp,
    output logic       o_pass
);
    typedef enum logic [2:0] {IDLE, CHECK, OPEN, DENY, MAINT} state_t;

    localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] DENY_LAST = TMR_W'(DENY_CYCLES - 1);

    state_t            r_state, w_nxt;
    logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
    logic [2:0]        r_code, w_code_nxt, w_disp_nxt;
    logic              w_reduce;
    logic              r_open, r_reduce;
    logic [2:0]        r_disp;

    always_comb begin
        w_nxt      = r_state;
        w_tmr_nxt  = r_tmr;
        w_code_nxt = r_code;
        w_reduce   = 1'b0;
        o_pass     = 1'b0;
        // Maintenance pre-empts every transition, including passage and fare deduction.
        if (i_maintenance) begin
            w_nxt     = MAINT;
            w_tmr_nxt = '0;
        end else begin
            case (r_state)
                IDLE:  if (i_nfc) w_nxt = CHECK;
                CHECK: begin
                    w_tmr_nxt = '0;
                    if (!i_card_active) begin
                        w_nxt      = DENY;
                        w_code_nxt = 3'b001;
                    end else if (!i_fund_enough) begin
                        w_nxt      = DENY;
                        w_code_nxt = 3'b010;
                    end else begin
                        w_nxt    = OPEN;
                        w_reduce = 1'b1;
                    end
                end
                OPEN: begin
                    if (i_pass_done) begin
                        w_nxt     = IDLE;
                        w_tmr_nxt = '0;
                        o_pass    = 1'b1;
                    end else if (r_tmr == OPEN_LAST) begin
                        w_nxt     = IDLE;
                        w_tmr_nxt = '0;
                    end else begin
                        w_tmr_nxt = r_tmr + 1'b1;
                    end
                end
                DENY: begin
                    if (r_tmr == DENY_LAST) begin
                        w_nxt     = IDLE;
                        w_tmr_nxt = '0;
                    end else begin
                        w_tmr_nxt = r_tmr + 1'b1;
                    end
                end
                default: w_nxt = IDLE;
            endcase
        end

        case (w_nxt)
            OPEN:    w_disp_nxt = 3'b011;
            DENY:    w_disp_nxt = w_code_nxt;
            MAINT:   w_disp_nxt = 3'b100;
            default: w_disp_nxt = 3'b000;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_tmr    <= '0;
            r_code   <= 3'b000;
            r_open   <= 1'b0;
            r_reduce <= 1'b0;
            r_disp   <= 3'b000;
        end else begin
            r_state  <= w_nxt;
            r_tmr    <= w_tmr_nxt;
            r_code   <= w_code_nxt;
            r_open   <= (w_nxt == OPEN);
            r_reduce <= w_reduce;
            r_disp   <= w_disp_nxt;
        end
    end

    assign o_open       = r_open;
    assign o_reduce_bal = r_reduce;
    assign o_disp       = r_disp;
endmodule

module fare_gate_array_ctrl #(
    parameter int N_LANES     = 4,
    parameter int OPEN_CYCLES = 50,
    parameter int DENY_CYCLES = 20,
    parameter int CNT_W       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_maintenance,
    input  logic [N_LANES-1:0]     i_nfc,
    input  logic [N_LANES-1:0]     i_card_active,
    input  logic [N_LANES-1:0]     i_fund_enough,
    input  logic [N_LANES-1:0]     i_pass_done,
    output logic [N_LANES-1:0]     o_open,
    output logic [N_LANES-1:0]     o_reduce_bal,
    output logic [3*N_LANES-1:0]   o_disp,
    output logic [CNT_W-1:0]       o_entry_count
);
    localparam int TMR_MAX = (OPEN_CYCLES > DENY_CYCLES) ? OPEN_CYCLES : DENY_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    // Wide enough for count + every lane passing at once without wrapping.
    localparam int SUM_W   = CNT_W + $clog2(N_LANES + 1) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [N_LANES-1:0] w_pass;
    logic [SUM_W-1:0]   w_total;
    logic [CNT_W-1:0]   r_count;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        fare_gate_lane #(
            .OPEN_CYCLES(OPEN_CYCLES),
            .DENY_CYCLES(DENY_CYCLES),
            .TMR_W      (TMR_W)
        ) u_lane (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_maintenance(i_maintenance),
            .i_nfc        (i_nfc[g]),
            .i_card_active(i_card_active[g]),
            .i_fund_enough(i_fund_enough[g]),
            .i_pass_done  (i_pass_done[g]),
            .o_open       (o_open[g]),
            .o_reduce_bal (o_reduce_bal[g]),
            .o_disp       (o_disp[3*g +: 3]),
            .o_pass       (w_pass[g])
        );
    end

    always_comb begin
        w_total = SUM_W'(r_count);
        for (int i = 0; i < N_LANES; i++) w_total = w_total + SUM_W'(w_pass[i]);
        if (w_total > CNT_MAX) w_total = CNT_MAX;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_count <= '0;
        else          r_count <= w_total[CNT_W-1:0];
    end

    assign o_entry_count = r_count;
endmodule

// File: tb/tb_fare_gate_array_ctrl.sv
// Directed bench for fare_gate_array_ctrl with 2 lanes, short timers and a 4-bit counter.
module tb_fare_gate_array_ctrl;
    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         maint = 1'b0;
    logic [N-1:0] nfc = '0, card = '0, fund = '0, pass = '0;
    logic [N-1:0] open_o, red_o;
    logic [3*N-1:0] disp_o;
    logic [3:0]   cnt_o;

    int checks = 0;
    int failures = 0;

    fare_gate_array_ctrl #(.N_LANES(N), .OPEN_CYCLES(8), .DENY_CYCLES(4), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_maintenance(maint),
        .i_nfc(nfc), .i_card_active(card), .i_fund_enough(fund), .i_pass_done(pass),
        .o_open(open_o), .o_reduce_bal(red_o), .o_disp(disp_o), .o_entry_count(cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tap then present valid card/funds; returns in the first OPEN cycle.
    task automatic accept(input logic [N-1:0] m);
        nfc = m; tick(); nfc = '0;
        card = m; fund = m; tick(); card = '0; fund = '0;
    endtask

    initial begin
        #12;
        chk("rst_open", open_o, 0);
        chk("rst_red", red_o, 0);
        chk("rst_disp", disp_o, 0);
        chk("rst_cnt", cnt_o, 0);
        rst_n = 1'b1;
        tick();

        // Happy path lane 0
        nfc = 2'b01; tick(); nfc = '0;
        chk("hp_check_open", open_o, 0);
        card = 2'b01; fund = 2'b01; tick(); card = '0; fund = '0;
        chk("hp_red", red_o, 2'b01);
        chk("hp_open1", open_o, 2'b01);
        chk("hp_disp", disp_o, 6'b000_011);
        tick();
        chk("hp_red_once", red_o, 0);
        tick();
        chk("hp_open3", open_o, 2'b01);
        pass = 2'b01; tick(); pass = '0;
        chk("hp_closed", open_o, 0);
        chk("hp_cnt", cnt_o, 1);

        // Invalid card lane 1 (funds also low: card error wins)
        nfc = 2'b10; tick(); nfc = '0; tick();
        for (int k = 0; k < 4; k++) begin
            chk("inv_disp", disp_o, 6'b001_000);
            chk("inv_open", open_o, 0);
            chk("inv_red", red_o, 0);
            tick();
        end
        chk("inv_ready", disp_o, 0);

        // Insufficient funds lane 1
        nfc = 2'b10; tick(); nfc = '0; card = 2'b10; tick(); card = '0;
        for (int k = 0; k < 4; k++) begin
            chk("fund_disp", disp_o, 6'b010_000);
            tick();
        end
        chk("fund_ready", disp_o, 0);

        // Timeout lane 0
        accept(2'b01);
        for (int k = 0; k < 8; k++) begin
            chk("to_open", open_o, 2'b01);
            tick();
        end
        chk("to_closed", open_o, 0);
        chk("to_disp", disp_o, 0);
        chk("to_cnt", cnt_o, 1);

        // Maintenance: lane 0 OPEN, lane 1 in CHECK with a valid card
        accept(2'b01);
        nfc = 2'b10; tick(); nfc = '0;
        card = 2'b10; fund = 2'b10; maint = 1'b1; tick();
        chk("mt_disp", disp_o, 6'b100_100);
        chk("mt_open", open_o, 0);
        chk("mt_red", red_o, 0);
        nfc = 2'b11; card = 2'b11; fund = 2'b11; pass = 2'b11; tick(); tick();
        nfc = '0; card = '0; fund = '0; pass = '0;
        chk("mt_tap_disp", disp_o, 6'b100_100);
        chk("mt_tap_open", open_o, 0);
        chk("mt_tap_red", red_o, 0);
        chk("mt_cnt", cnt_o, 1);
        maint = 1'b0; tick();
        chk("mt_exit", disp_o, 0);

        // Dual passage
        accept(2'b11);
        chk("dual_red", red_o, 2'b11);
        pass = 2'b11; tick(); pass = '0;
        chk("dual_cnt", cnt_o, 3);
        for (int k = 0; k < 5; k++) begin
            accept(2'b11); pass = 2'b11; tick(); pass = '0;
        end
        chk("cnt13", cnt_o, 13);
        accept(2'b01); pass = 2'b01; tick(); pass = '0;
        chk("cnt14", cnt_o, 14);
        accept(2'b11); pass = 2'b11; tick(); pass = '0;
        chk("sat15", cnt_o, 15);
        accept(2'b11); pass = 2'b11; tick(); pass = '0;
        chk("sat_hold", cnt_o, 15);

        // Asynchronous reset mid-OPEN
        accept(2'b01);
        chk("pre_rst_open", open_o, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("arst_open", open_o, 0);
        chk("arst_red", red_o, 0);
        chk("arst_disp", disp_o, 0);
        chk("arst_cnt", cnt_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fare_gate_array_ctrl.md
Name: fare_gate_array_ctrl

Overview:
- Multi-lane successor to the single-lane fare gate FSM.
- Runs N_LANES independent gate state machines: card tap → validation → open or deny, with per-lane open/deny timers, passage detection and a shared saturating entry counter.
- Global maintenance mode forces every lane closed.
- Sits between the per-lane NFC reader/fare back-end and the door actuators/lane displays.

Parameters:
- N_LANES, 4, number of independent gate lanes.
- OPEN_CYCLES, 50, maximum cycles a door stays open awaiting passage (≥ 2).
- DENY_CYCLES, 20, cycles an error code is displayed before returning to ready (≥ 1).
- CNT_W, 16, width of the entry counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- maintenance  in  1  global maintenance request, level, synchronous.
- nfc  in  N_LANES  per-lane card tap strobe.
- card_active  in  N_LANES  per-lane card validity, valid the cycle after nfc.
- fund_enough  in  N_LANES  per-lane sufficient-fare flag, valid the cycle after nfc.
- pass_done  in  N_LANES  per-lane beam sensor: passenger has cleared the gate.
- open  out  N_LANES  per-lane door open command.
- reduce_bal  out  N_LANES  per-lane one-cycle fare deduction pulse.
- disp  out  3*N_LANES  per-lane display code; lane i uses bits [3i+2:3i].
- entry_count  out  CNT_W  total completed passages across all lanes.

Behaviour:
- Reset (async assert, sync release): all lanes in IDLE; open=0, reduce_bal=0, disp=000 for every lane, entry_count=0, all timers 0.
- Display codes: 000 ready, 001 invalid card, 010 insufficient funds, 011 open, 100 maintenance.
- All outputs are registered.
- Per-lane states: IDLE, CHECK, OPEN, DENY, MAINT.
- Global rule: maintenance=1 at any edge puts every lane in MAINT on the next cycle, from any state. This overrides all other transitions, including a concurrent CHECK→OPEN, so no reduce_bal is issued.
- MAINT: open=0, disp=100, all lane inputs ignored. When maintenance=0 is sampled, the lane goes to IDLE next cycle.
- IDLE: disp=000. nfc=1 → CHECK.
- CHECK: exactly one cycle; card_active and fund_enough are sampled here.
  - card_active=0 → DENY with disp=001. Invalid card takes priority over funds.
  - card_active=1 and fund_enough=0 → DENY with disp=010.
  - Both 1 → OPEN.
- reduce_bal is high for exactly the first cycle in OPEN, once per accepted tap.
- OPEN: open=1, disp=011, timer counts from 0.
  - pass_done=1 → IDLE next cycle and entry_count increments.
  - Otherwise, after OPEN_CYCLES cycles in OPEN → IDLE with no increment.
  - pass_done on the final timeout cycle counts as a passage.
- DENY: open=0. Holds its error code for exactly DENY_CYCLES cycles, then IDLE.
- nfc is ignored in CHECK, OPEN, DENY and MAINT; there is no queuing of taps.
- pass_done is ignored outside OPEN, so a tailgater with no accepted tap is not counted.
- entry_count:
  - Increments by the number of lanes completing a passage in the same cycle (0..N_LANES).
  - Saturates at 2^CNT_W−1; it never wraps.
  - Not cleared by maintenance.
- Lanes are fully independent except for maintenance and entry_count.
- Timer width is clog2(max(OPEN_CYCLES, DENY_CYCLES)+1).

Test Plan:
Bench parameters: N_LANES=2, OPEN_CYCLES=8, DENY_CYCLES=4, CNT_W=4.
- Happy path, lane 0: nfc=1 for one cycle, then card_active=1 and fund_enough=1. Required: reduce_bal[0] pulses one cycle; open[0]=1 and disp=011 from the cycle after CHECK. pass_done[0]=1 at open cycle 3 → open[0]=0 next cycle and entry_count=1.
- Invalid vs funds, lane 1:
  - Tap with card_active=0, fund_enough=0 → disp=001 for 4 cycles, open=0, no reduce_bal, then 000.
  - Tap with card_active=1, fund_enough=0 → disp=010 for 4 cycles.
- Timeout: accepted tap on lane 0 with no pass_done. Required: open[0]=1 for exactly 8 cycles, then IDLE; entry_count unchanged.
- Maintenance:
  - Assert maintenance while lane 0 is OPEN and lane 1 is in CHECK. Required: next cycle both disp=100 and open=00; no reduce_bal[1].
  - nfc taps during maintenance produce no response.
  - Deassert → both lanes show 000 the following cycle.
- Concurrency and saturation:
  - Both lanes accepted, pass_done=11 in the same cycle → entry_count +2.
  - Preload to 14, then a dual passage → entry_count stays at 15.
- Reset mid-operation: drive rst_n=0 asynchronously while lane 0 is OPEN. Required: open, reduce_bal, disp and entry_count go to 0 immediately, before the next clock edge.
